// File: rtl/key_schedule_gen.sv
// key_schedule_gen: parametrised AES key expansion (AES-128/192/256 via NK).
// Produces one 32-bit schedule word per advancing cycle and streams each
// completed 128-bit round key over a valid/ready handshake.
// Optional feature macro: KEY_SCHED_SRAM_WR_EN adds a registered SRAM write
// port (sram_write / sram_addr / sram_write_value) fed by accepted round keys.

// Combinational AES S-box, one byte in, one byte out.
module sbox (
    input  logic [7:0] inByte,
    output logic [7:0] outByte
);
    // Entry 0 sits in the top byte so the table reads in natural order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] topBit;

    // Top bit of entry n is 2047 - 8n, which is the bitwise inverse of 8n.
    assign topBit  = ~{inByte, 3'b000};
    assign outByte = SBOX_TABLE[topBit -: 8];
endmodule

module key_schedule_gen #(
    parameter int          NK        = 4,
    parameter logic [15:0] SRAM_BASE = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NK*32-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_index,
    output logic [127:0]     rk_data
`ifdef KEY_SCHED_SRAM_WR_EN
    ,
    output logic             sram_write,
    output logic [15:0]      sram_addr,
    output logic [127:0]     sram_write_value
`endif
);
    localparam int          NR          = NK + 6;
    localparam logic [5:0]  TOTAL_WORDS = 6'(4 * (NR + 1));
    localparam logic [5:0]  NK_WORDS    = 6'(NK);
    localparam logic [2:0]  LAST_MOD    = 3'(NK - 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : gIllegalNk
        $error("key_schedule_gen: NK must be 4, 6 or 8");
    end

    if (({1'b0, SRAM_BASE} + 17'(NR)) > 17'h0ffff) begin : gSramWrap
        $error("key_schedule_gen: SRAM_BASE + NR wraps the 16-bit address space");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t      stateQ, stateD;
    logic [5:0]  wordCnt;          // schedule word index i
    logic [2:0]  modCnt;           // i mod NK, tracked without a divider
    logic [7:0]  rcon;
    logic [31:0] window [NK];      // window[0] = w[i-NK] ... window[NK-1] = w[i-1]
    logic [95:0] collector;        // first three words of the round key in flight

    logic        handshake;
    logic        advance;
    logic        lastAccepted;
    logic        startAccept;
    logic [31:0] prevWord;
    logic [31:0] subIn;
    logic [31:0] subOut;
    logic [31:0] temp;
    logic [31:0] newWord;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign handshake    = rk_valid && rk_ready;
    assign lastAccepted = handshake && (rk_index == 4'(NR));
    // A done pulse marks the cycle a start would otherwise slip in; ignore it.
    assign startAccept  = (stateQ == IDLE) && start && !done;
    // Freeze while a finished key waits, and stop once every word is out.
    assign advance      = (stateQ == RUN) && (wordCnt != TOTAL_WORDS)
                          && !(rk_valid && !rk_ready);

    // SubWord over RotWord(w[i-1]) on Rcon words, over w[i-1] otherwise.
    assign prevWord = window[NK-1];
    assign subIn    = (modCnt == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    for (genvar b = 0; b < 4; b++) begin : gSubWord
        sbox uSbox (
            .inByte (subIn[8*b +: 8]),
            .outByte(subOut[8*b +: 8])
        );
    end

    // Next schedule word from the window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        temp    = prevWord;
        newWord = window[0];
        if (modCnt == 3'd0) begin
            temp = subOut ^ {rcon, 24'h0};
        end else if (NK == 8 && modCnt == 3'd4) begin
            temp = subOut;
        end
        if (wordCnt >= NK_WORDS) begin
            newWord = window[0] ^ temp;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (startAccept)  stateD = RUN;
            RUN:     if (lastAccepted) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (stateQ == RUN);
    end

    // Word generator, collector and round-key output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the window is cleared too, so no key material outlives a reset.
            for (int j = 0; j < NK; j++) window[j] <= '0;
            wordCnt   <= '0;
            modCnt    <= '0;
            rcon      <= '0;
            collector <= '0;
            rk_valid  <= 1'b0;
            rk_index  <= '0;
            rk_data   <= '0;
            done      <= 1'b0;
        end else begin
            done <= lastAccepted;
            if (startAccept) begin
                for (int j = 0; j < NK; j++) window[j] <= key_in[32*j +: 32];
                wordCnt <= '0;
                modCnt  <= '0;
                rcon    <= 8'h01;
            end else begin
                if (handshake) rk_valid <= 1'b0;
                if (advance) begin
                    wordCnt <= wordCnt + 6'd1;
                    modCnt  <= (modCnt == LAST_MOD) ? 3'd0 : modCnt + 3'd1;
                    if (wordCnt >= NK_WORDS && modCnt == 3'd0) rcon <= xtime(rcon);
                    // Key words rotate through unchanged, leaving w[0..NK-1] in place at i=NK.
                    for (int j = 0; j < NK - 1; j++) window[j] <= window[j+1];
                    window[NK-1] <= newWord;
                    case (wordCnt[1:0])
                        2'd0: collector[31:0]  <= newWord;
                        2'd1: collector[63:32] <= newWord;
                        2'd2: collector[95:64] <= newWord;
                        default: begin
                            rk_data  <= {newWord, collector};
                            rk_index <= wordCnt[5:2];
                            rk_valid <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

`ifdef KEY_SCHED_SRAM_WR_EN
    // Mirror each accepted round key into the round-key SRAM one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_write       <= 1'b0;
            sram_addr        <= '0;
            sram_write_value <= '0;
        end else begin
            sram_write <= handshake;
            if (handshake) begin
                sram_addr        <= SRAM_BASE + 16'(rk_index);
                sram_write_value <= rk_data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen: AES-128/192/256 vectors, latency,
// backpressure, start-while-busy, mid-run reset and the optional SRAM port.
module tb_key_schedule_gen;
    localparam logic [127:0] KEY4 = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [191:0] KEY6 = 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
    localparam logic [255:0] KEY8 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;

    logic [127:0] rk4Exp [0:10] = '{
        128'h09cf4f3c_abf71588_28aed2a6_2b7e1516,
        128'h2a6c7605_23a33939_88542cb1_a0fafe17,
        128'h7359f67f_5935807a_7a96b943_f2c295f2,
        128'h6d7a883b_1e237e44_4716fe3e_3d80477d,
        128'hdb0bad00_b671253b_a8525b7f_ef44a541,
        128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8,
        128'hca0093fd_dbf98641_110b3efd_6d88a37a,
        128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e,
        128'h7f8d292f_312bf560_b58dbad2_ead27321,
        128'h575c006e_28d12941_19fadc21_ac7766f3,
        128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8
    };

    int nVectors     = 0;
    int nMiscompares = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start4 = 1'b0, ready4 = 1'b1;
    logic [127:0] key4 = KEY4;
    logic         busy4, done4, valid4;
    logic [3:0]   index4;
    logic [127:0] data4;

    logic         start6 = 1'b0, ready6 = 1'b1;
    logic [191:0] key6 = KEY6;
    logic         busy6, done6, valid6;
    logic [3:0]   index6;
    logic [127:0] data6;

    logic         start8 = 1'b0, ready8 = 1'b1;
    logic [255:0] key8 = KEY8;
    logic         busy8, done8, valid8;
    logic [3:0]   index8;
    logic [127:0] data8;

`ifdef KEY_SCHED_SRAM_WR_EN
    logic sramWrite4, sramWrite6, sramWrite8;
    logic [15:0] sramAddr4, sramAddr6, sramAddr8;
    logic [127:0] sramValue4, sramValue6, sramValue8;
`endif

    key_schedule_gen #(.NK(4), .SRAM_BASE(16'h0010)) u4 (
        .clk(clk), .rst(rst), .start(start4), .key_in(key4), .busy(busy4), .done(done4),
        .rk_valid(valid4), .rk_ready(ready4), .rk_index(index4), .rk_data(data4)
`ifdef KEY_SCHED_SRAM_WR_EN
        , .sram_write(sramWrite4), .sram_addr(sramAddr4), .sram_write_value(sramValue4)
`endif
    );

    key_schedule_gen #(.NK(6)) u6 (
        .clk(clk), .rst(rst), .start(start6), .key_in(key6), .busy(busy6), .done(done6),
        .rk_valid(valid6), .rk_ready(ready6), .rk_index(index6), .rk_data(data6)
`ifdef KEY_SCHED_SRAM_WR_EN
        , .sram_write(sramWrite6), .sram_addr(sramAddr6), .sram_write_value(sramValue6)
`endif
    );

    key_schedule_gen #(.NK(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .key_in(key8), .busy(busy8), .done(done8),
        .rk_valid(valid8), .rk_ready(ready8), .rk_index(index8), .rk_data(data8)
`ifdef KEY_SCHED_SRAM_WR_EN
        , .sram_write(sramWrite8), .sram_addr(sramAddr8), .sram_write_value(sramValue8)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // NK=4 monitor: every presented key must be the next expected one, held until taken.
    int expIdx4  = 0;
    bit mon4En   = 1'b1;
    bit hsPrev4  = 1'b0;
    int hsIdx4   = 0;
    int sramCnt4 = 0;
    always @(negedge clk) begin
`ifdef KEY_SCHED_SRAM_WR_EN
        if (mon4En) begin
            check("sram_write_pulse", sramWrite4, hsPrev4);
            if (sramWrite4 && hsPrev4) begin
                check("sram_addr", sramAddr4, 16'h0010 + 16'(hsIdx4));
                check("sram_value", sramValue4, rk4Exp[hsIdx4]);
                sramCnt4++;
            end
        end
        hsPrev4 = mon4En && valid4 && ready4 && !rst;
        hsIdx4  = expIdx4;
`endif
        if (mon4En && valid4) begin
            if (expIdx4 > 10) begin
                check("rk4_extra_valid", valid4, 1'b0);
            end else begin
                check("rk4_index", index4, expIdx4);
                check("rk4_data", data4, rk4Exp[expIdx4]);
                if (ready4) expIdx4++;
            end
        end
    end

    // NK=6 / NK=8 monitors: count accepted keys and check the known ones.
    int cnt6 = 0;
    always @(negedge clk) begin
        if (valid6 && ready6 && !rst) begin
            check("rk6_index", index6, cnt6);
            if (cnt6 == 0)  check("rk6_0", data6, 128'h809079e5_c810f32b_da0e6452_8e73b0f7);
            if (cnt6 == 1)  check("rk6_1_low", data6[63:0], 64'h522c6b7b_62f8ead2);
            if (cnt6 == 12) check("rk6_12", data6, 128'h01002202_8ecc7204_448c773c_e98ba06f);
            cnt6++;
        end
    end

    int cnt8 = 0;
    always @(negedge clk) begin
        if (valid8 && ready8 && !rst) begin
            check("rk8_index", index8, cnt8);
            if (cnt8 == 0)  check("rk8_0", data8, 128'h857d7781_2b73aef0_15ca71be_603deb10);
            if (cnt8 == 1)  check("rk8_1", data8, 128'h0914dff4_2d9810a3_3b6108d7_1f352c07);
            if (cnt8 == 14) check("rk8_14", data8, 128'h706c631e_046df344_e6188d0b_fe4890d1);
            cnt8++;
        end
    end

    // Full NK=4 run with ready high; pokeStart also pulses start mid-run and on done.
    task automatic runFull4(input bit pokeStart);
        expIdx4  = 0;
        sramCnt4 = 0;
        ready4   = 1'b1;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int c = 1; c <= 46; c++) begin
            @(posedge clk); #1;
            if (pokeStart && (c == 10 || c == 45)) begin
                start4 = 1'b1;
                key4   = ~KEY4;
            end else begin
                start4 = 1'b0;
                key4   = KEY4;
            end
            @(negedge clk);
            check("rk4_valid_timing", valid4, (c >= 4 && c <= 44 && c % 4 == 0));
            check("busy4", busy4, c <= 44);
            check("done4_timing", done4, c == 45);
        end
        start4 = 1'b0;
        key4   = KEY4;
        check("rk4_count", expIdx4, 11);
`ifdef KEY_SCHED_SRAM_WR_EN
        check("sram_pulse_count", sramCnt4, 11);
`endif
    endtask

    task automatic runBackpressure4();
        bit sawDone  = 1'b0;
        bit didStall = 1'b0;
        int stallRun = 0;
        expIdx4 = 0;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (stallRun > 0) begin
                ready4 = 1'b0;
                stallRun--;
            end else if (valid4 && index4 == 4'd3 && !didStall) begin
                didStall = 1'b1;
                stallRun = 19;
                ready4   = 1'b0;
            end else begin
                ready4 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (done4) begin
                sawDone = 1'b1;
                check("bp_done_after_rk10", expIdx4, 11);
                break;
            end
            check("bp_busy", busy4, 1'b1);
        end
        check("bp_done_seen", sawDone, 1'b1);
        check("bp_long_stall_hit", didStall, 1'b1);
        ready4 = 1'b1;
    endtask

    task automatic runReset4();
        bit got5 = 1'b0;
        expIdx4 = 0;
        ready4  = 1'b1;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (valid4 && index4 == 4'd5) begin
                ready4 = 1'b0;
                got5   = 1'b1;
                break;
            end
        end
        check("rst_rk5_reached", got5, 1'b1);
        repeat (3) @(posedge clk);
        #1 mon4En = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", valid4, 1'b0);
        check("rst_mid_busy", busy4, 1'b0);
        check("rst_mid_index", index4, 4'd0);
        check("rst_mid_data", data4, 128'h0);
        ready4 = 1'b1;
        mon4En = 1'b1;
        runFull4(1'b0);
    endtask

    task automatic runNk6();
        int doneAt = -1;
        cnt6 = 0;
        @(posedge clk); #1 start6 = 1'b1;
        @(posedge clk); #1 start6 = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); @(negedge clk);
            if (done6) begin
                doneAt = c;
                break;
            end
        end
        check("rk6_count", cnt6, 13);
        check("rk6_done_cycle", doneAt, 53);
    endtask

    task automatic runNk8();
        int doneAt = -1;
        cnt8 = 0;
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk); @(negedge clk);
            if (done8) begin
                doneAt = c;
                break;
            end
        end
        check("rk8_count", cnt8, 15);
        check("rk8_done_cycle", doneAt, 61);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy4", busy4, 1'b0);
        check("reset_done4", done4, 1'b0);
        check("reset_valid4", valid4, 1'b0);
        check("reset_index4", index4, 4'd0);
        check("reset_data4", data4, 128'h0);
        check("reset_busy6", busy6, 1'b0);
        check("reset_busy8", busy8, 1'b0);
`ifdef KEY_SCHED_SRAM_WR_EN
        check("reset_sram_write", sramWrite4, 1'b0);
        check("reset_sram_addr", sramAddr4, 16'h0);
        check("reset_sram_value", sramValue4, 128'h0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        runFull4(1'b0);
        runFull4(1'b1);
        runBackpressure4();
        runReset4();
        runNk6();
        runNk8();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule

// File: doc/key_schedule_gen.md
Name: key_schedule_gen

Overview:
Parametrised AES key-expansion engine and successor to the team's AES-128-only keyExpansion block. It supports AES-128, AES-192 and AES-256 through parameter NK. It generates one 32-bit schedule word per cycle and streams complete 128-bit round keys out through a valid/ready handshake, instead of one SRAM round per enable. It sits between the key-load front end and the round-key store / cipher core.

Parameters:
NK, 4, key length in 32-bit words; legal values 4/6/8 (AES-128/192/256); any other value is a compile-time error
NR, NK+6, number of rounds (derived, not to be overridden); round keys emitted = NR+1 (11/13/15)
SRAM_BASE, 16'h0000, base address for the optional SRAM write port

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset: synchronous, active-high
start  in  1  begin expansion; sampled only when busy=0
key_in  in  NK*32  cipher key; word i at [32i+31:32i], first key byte in the MSB of word 0
busy  out  1  expansion in progress
done  out  1  one-cycle pulse on acceptance of the final round key
rk_valid  out  1  rk_data/rk_index valid
rk_ready  in  1  consumer accepts the round key when rk_valid&&rk_ready at a rising edge
rk_index  out  4  round-key number k, 0..NR
rk_data  out  128  round key k: word w[4k+j] at [32j+31:32j]

Behaviour:
- Reset (rst=1 at an edge): busy=0, done=0, rk_valid=0, rk_index=0, rk_data=0; word counter, window, collector and Rcon cleared. Reset takes effect mid-operation with no partial output afterwards.
- States:
  - IDLE: busy=0.
  - RUN.
  - IDLE -> RUN when start=1 at an edge. At that edge key_in is captured into an NK-word window and Rcon is set to 8'h01.
  - RUN -> IDLE at the edge where the last key (k=NR) handshakes; done=1 for the following cycle.
- start is ignored while busy=1. start asserted in the same cycle as done is ignored.
- Word stream, word counter i = 0 .. 4*(NR+1)-1, one word per advancing cycle:
  - i<NK: w[i] = key word i.
  - Otherwise temp = w[i-1], and:
    - i mod NK==0: temp = SubWord(RotWord(temp)) xor {Rcon,24'h0}. Rcon then updates by xtime (shift left 1; xor 8'h1B if bit7 was set).
    - NK==8 and i mod 8==4: temp = SubWord(temp).
    - w[i] = w[i-NK] xor temp.
  - The window shifts by one word each advance.
- SubWord uses four instances of the team's combinational sbox block; there are no extra pipeline stages.
- Collector: words for i mod 4 = 0..2 are held in the collector. At the edge producing i mod 4==3:
  - rk_data <= {w[i], collector[95:0]}
  - rk_index <= i/4
  - rk_valid <= 1
- Stall: the generator advances only when !(rk_valid && !rk_ready). A held rk_data/rk_index must stay stable until accepted.
- On a handshake with no new key loaded at the same edge, rk_valid <= 0.
- Latency with rk_ready=1 throughout: start sampled at edge E0; rk k valid after edge E(4k+4) for exactly one cycle. Total 4*(NR+1)+1 cycles from start to done pulse.
- Throughput: one round key per 4 cycles.
- rk_ready held low indefinitely: the engine freezes and busy stays 1.

Optional Feature:
Macro KEY_SCHED_SRAM_WR_EN.
- Defined: extra outputs sram_write (1), sram_addr (16), sram_write_value (128). Each output is registered, so it appears the cycle after each rk handshake. sram_write=1 for one cycle, sram_addr = SRAM_BASE + rk_index of the accepted key, sram_write_value = accepted rk_data. All three reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- NK=4, key_in=128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516, start pulse, rk_ready=1:
  - rk1 = 128'h2A6C7605_23A33939_88542CB1_A0FAFE17
  - rk10 = 128'hB6630CA6_E13F0CC8_C9EE2589_D014F9A8
  - rk0 = key; rk_valid every 4th cycle; done 45 cycles after start.
- NK=6, FIPS-197 A.2 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - rk12 = 128'h01002202_8ecc7204_448c773c_e98ba06f
  - 13 keys, indices 0..12.
- NK=8, FIPS-197 A.3 key 603deb10..0914dff4:
  - rk14 = 128'h706c631e_046df344_e6188d0b_fe4890d1
  - 15 keys, indices 0..14.
- Backpressure: NK=4, rk_ready random at 50%, including a 20-cycle low run on rk3:
  - rk_data/rk_index stable while stalled.
  - Sequence identical to the first scenario; done only after rk10 is accepted.
- Control: start pulsed while busy -> ignored, output unchanged. rst=1 during rk5 wait -> next cycle rk_valid=0, busy=0; a fresh start then reproduces rk0..rk10.
- With KEY_SCHED_SRAM_WR_EN, SRAM_BASE=16'h0010, NK=4: eleven sram_write pulses, addr 0x0010..0x001A, data equal to rk0..rk10, each one cycle after its handshake.
